// File: rtl/exu_mc.sv
// exu_mc: multicycle execute stage with a req/ack memory port,
// bus timeout with sticky error, and a one-cycle commit pulse.
module exu_mc #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         opcode,
  input  logic [2:0]         funct,
  input  logic [RADDR_W-1:0] rd,
  input  logic [XLEN-1:0]    src1,
  input  logic [XLEN-1:0]    src2,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    alu_val,
  output logic               mem_req,
  output logic               mem_we,
  output logic [2:0]         mem_func,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_ack,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               commit,
  output logic               reg_wen,
  output logic [RADDR_W-1:0] reg_waddr,
  output logic [XLEN-1:0]    reg_wdata,
  output logic [XLEN-1:0]    pc_inc,
  output logic               pc_ovrd,
  output logic [XLEN-1:0]    pc_ovrd_addr,
  output logic               bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    DONE
  } state_t;

  state_t state, state_n;

  logic [4:0]         op_q;
  logic [2:0]         funct_q;
  logic [RADDR_W-1:0] rd_q;
  logic [XLEN-1:0]    src1_q;
  logic [XLEN-1:0]    src2_q;
  logic [XLEN-1:0]    imm_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    rdata_q;
  logic [XLEN-1:0]    pc_inc_q;
  logic [XLEN-1:0]    pc_inc_n;
  logic [CW-1:0]      cnt;
  logic               to_q;
  logic               err_q;

  logic acc, in_mem, ack, tmo;
  logic is_ld, is_st, is_br, is_jalr, is_jal;
  logic zf, taken;

  assign acc    = in_valid & in_ready;
  assign in_mem = (opcode == OP_LOAD) | (opcode == OP_STORE);
  assign ack    = (state == MEM) & mem_ack;
  // An ack in the final wait cycle still completes normally.
  assign tmo    = (state == MEM) & ~mem_ack
                & (cnt == CW'(MAX_WAIT - 1));

  assign is_ld   = (op_q == OP_LOAD);
  assign is_st   = (op_q == OP_STORE);
  assign is_br   = (op_q == OP_BRANCH);
  assign is_jalr = (op_q == OP_JALR);
  assign is_jal  = (op_q == OP_JAL);
  assign zf      = (alu_q == '0);

  always_comb begin
    taken = 1'b0;
    unique case (funct_q)
      3'b000:         taken = zf;
      3'b001:         taken = ~zf;
      3'b100, 3'b110: taken = alu_q[0];
      3'b101, 3'b111: taken = ~alu_q[0];
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = in_mem ? MEM : DONE;
      MEM:  if (ack | tmo) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      funct_q  <= '0;
      rd_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      pc_inc_q <= XLEN'(4);
      cnt      <= '0;
      to_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        op_q    <= opcode;
        funct_q <= funct;
        rd_q    <= rd;
        src1_q  <= src1;
        src2_q  <= src2;
        imm_q   <= imm;
        alu_q   <= alu_val;
        to_q    <= 1'b0;
      end
      if (state == MEM) begin
        if (ack) begin
          if (is_ld) rdata_q <= mem_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (tmo) begin
          to_q  <= 1'b1;
          err_q <= 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (state == DONE) pc_inc_q <= pc_inc_n;
    end
  end

  assign pc_inc_n = (is_jal | is_jalr | (is_br & taken))
                  ? imm_q : XLEN'(4);

  assign in_ready     = (state == IDLE);
  assign mem_req      = (state == MEM);
  assign mem_we       = is_st;
  assign mem_func     = funct_q;
  assign mem_addr     = alu_q;
  assign mem_wdata    = src2_q;
  assign commit       = (state == DONE);
  assign reg_wen      = commit
                      & ~(is_br | is_st | (is_ld & to_q));
  assign reg_waddr    = rd_q;
  assign reg_wdata    = is_ld ? rdata_q : alu_q;
  // pc_inc holds the last retired increment between commits.
  assign pc_inc       = commit ? pc_inc_n : pc_inc_q;
  assign pc_ovrd      = commit & is_jalr;
  assign pc_ovrd_addr = src1_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_exu_mc.sv
// tb_exu_mc: randomized transactions against a transaction-level
// model of exu_mc, with directed cases and a mid-MEM reset.
module tb_exu_mc;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int MW   = 4;

  localparam logic [4:0] LD = 5'b00000;
  localparam logic [4:0] ST = 5'b01000;
  localparam logic [4:0] BR = 5'b11000;
  localparam logic [4:0] JR = 5'b11001;
  localparam logic [4:0] JL = 5'b11011;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      opcode = '0;
  logic [2:0]      funct = '0;
  logic [RW-1:0]   rd = '0;
  logic [XLEN-1:0] src1 = '0, src2 = '0, imm = '0, alu_val = '0;
  logic            mem_req, mem_we;
  logic [2:0]      mem_func;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic            mem_ack = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            commit, reg_wen, pc_ovrd, bus_err;
  logic [RW-1:0]   reg_waddr;
  logic [XLEN-1:0] reg_wdata, pc_inc, pc_ovrd_addr;

  always #5 clk = ~clk;

  exu_mc #(.XLEN(XLEN), .RADDR_W(RW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rd(rd),
    .src1(src1), .src2(src2), .imm(imm), .alu_val(alu_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_func(mem_func),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .commit(commit), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_inc(pc_inc), .pc_ovrd(pc_ovrd),
    .pc_ovrd_addr(pc_ovrd_addr), .bus_err(bus_err)
  );

  typedef struct {
    logic [4:0]      op;
    logic [2:0]      f;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] s1, s2, imm, alu, rdata;
    int              d;
  } tr_t;

  int n_vec = 0;
  int n_err = 0;

  logic            chk = 1'b0;
  logic            m_err = 1'b0;
  logic [XLEN-1:0] m_pc = 32'd4;
  logic            e_ready = 1'b1, e_req = 1'b0, e_commit = 1'b0;
  logic            e_err = 1'b0, e_we = 1'b0, e_wen = 1'b0, e_ovrd = 1'b0;
  logic [2:0]      e_func = '0;
  logic [RW-1:0]   e_waddr = '0;
  logic [XLEN-1:0] e_addr = '0, e_wd = '0, e_wdata = '0;
  logic [XLEN-1:0] e_oaddr = '0, e_pc = 32'd4;

  logic            last_wen = 1'b0, last_ovrd = 1'b0;
  logic [XLEN-1:0] last_wdata = '0, last_pc = '0, last_oaddr = '0;

  task automatic cmp(input string name,
                     input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Increment the PC must take, straight from the branch/jump rules.
  function automatic logic [XLEN-1:0] pc_rule(input tr_t t);
    logic tk;
    case (t.f)
      3'd0:       tk = (t.alu == 0);
      3'd1:       tk = (t.alu != 0);
      3'd4, 3'd6: tk = t.alu[0];
      3'd5, 3'd7: tk = !t.alu[0];
      default:    tk = 1'b0;
    endcase
    if (t.op == JL || t.op == JR || (t.op == BR && tk))
      return t.imm;
    return 32'd4;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      cmp("in_ready", in_ready, e_ready);
      cmp("mem_req", mem_req, e_req);
      cmp("commit", commit, e_commit);
      cmp("bus_err", bus_err, e_err);
      cmp("pc_inc", pc_inc, e_pc);
      if (e_req) begin
        cmp("mem_we", mem_we, e_we);
        cmp("mem_func", mem_func, e_func);
        cmp("mem_addr", mem_addr, e_addr);
        cmp("mem_wdata", mem_wdata, e_wd);
      end
      if (e_commit) begin
        cmp("reg_wen", reg_wen, e_wen);
        cmp("reg_waddr", reg_waddr, e_waddr);
        cmp("pc_ovrd", pc_ovrd, e_ovrd);
        cmp("pc_ovrd_addr", pc_ovrd_addr, e_oaddr);
        if (e_wen) cmp("reg_wdata", reg_wdata, e_wdata);
        last_wen   = reg_wen;
        last_ovrd  = pc_ovrd;
        last_wdata = reg_wdata;
        last_pc    = pc_inc;
        last_oaddr = pc_ovrd_addr;
      end
    end
  end

  task automatic exp_idle();
    e_ready  = 1'b1;
    e_req    = 1'b0;
    e_commit = 1'b0;
    e_err    = m_err;
    e_pc     = m_pc;
  endtask

  task automatic noise();
    in_valid  = 1'($urandom);
    opcode    = 5'($urandom);
    funct     = 3'($urandom);
    rd        = RW'($urandom);
    src1      = $urandom;
    src2      = $urandom;
    imm       = $urandom;
    alu_val   = $urandom;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      exp_idle();
      in_valid = 1'b0;
      mem_ack  = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input tr_t t);
    bit mem, tmo;
    int n;
    mem = (t.op == LD) || (t.op == ST);
    tmo = mem && (t.d >= MW);
    n   = tmo ? MW : t.d + 1;
    exp_idle();
    in_valid = 1'b1;
    opcode   = t.op;
    funct    = t.f;
    rd       = t.rd;
    src1     = t.s1;
    src2     = t.s2;
    imm      = t.imm;
    alu_val  = t.alu;
    mem_ack  = 1'($urandom);
    @(posedge clk); #1;
    if (mem) begin
      for (int m = 0; m < n; m++) begin
        e_ready  = 1'b0;
        e_req    = 1'b1;
        e_commit = 1'b0;
        e_err    = m_err;
        e_we     = (t.op == ST);
        e_func   = t.f;
        e_addr   = t.alu;
        e_wd     = t.s2;
        noise();
        mem_ack   = (m == t.d);
        mem_rdata = (m == t.d) ? t.rdata : $urandom;
        @(posedge clk); #1;
      end
    end
    if (tmo) m_err = 1'b1;
    m_pc     = pc_rule(t);
    e_ready  = 1'b0;
    e_req    = 1'b0;
    e_commit = 1'b1;
    e_err    = m_err;
    e_pc     = m_pc;
    e_wen    = !(t.op == BR || t.op == ST || (t.op == LD && tmo));
    e_waddr  = t.rd;
    e_wdata  = (t.op == LD) ? t.rdata : t.alu;
    e_ovrd   = (t.op == JR);
    e_oaddr  = t.s1;
    noise();
    mem_ack  = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    exp_idle();
  endtask

  function automatic tr_t mk(input logic [4:0] op,
                             input logic [2:0] f,
                             input logic [RW-1:0] r,
                             input logic [XLEN-1:0] s1, s2, im, al, rdat,
                             input int d);
    tr_t t;
    t.op = op; t.f = f; t.rd = r; t.s1 = s1; t.s2 = s2;
    t.imm = im; t.alu = al; t.rdata = rdat; t.d = d;
    return t;
  endfunction

  function automatic tr_t rnd();
    tr_t t;
    case ($urandom_range(0, 8))
      0: t.op = LD;
      1: t.op = ST;
      2: t.op = BR;
      3: t.op = JR;
      4: t.op = JL;
      5: t.op = 5'b00100;
      6: t.op = 5'b01100;
      7: t.op = 5'b01101;
      default: t.op = 5'($urandom);
    endcase
    t.f     = 3'($urandom);
    t.rd    = RW'($urandom);
    t.s1    = $urandom;
    t.s2    = $urandom;
    t.imm   = $urandom;
    t.alu   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3))
                                          : $urandom;
    t.rdata = $urandom;
    t.d     = $urandom_range(0, MW + 1);
    return t;
  endfunction

  initial begin
    @(posedge clk);
    @(negedge clk);
    cmp("rst_in_ready", in_ready, 1);
    cmp("rst_mem_req", mem_req, 0);
    cmp("rst_commit", commit, 0);
    cmp("rst_reg_wen", reg_wen, 0);
    cmp("rst_pc_ovrd", pc_ovrd, 0);
    cmp("rst_bus_err", bus_err, 0);
    cmp("rst_pc_inc", pc_inc, 32'd4);
    cmp("rst_mem_addr", mem_addr, 0);
    cmp("rst_reg_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_idle();
    chk = 1'b1;

    run(mk(5'b00100, 3'd0, 5, 0, 0, 32'h77, 32'h1234, 0, 0));
    cmp("addi_wdata", last_wdata, 32'h1234);
    cmp("addi_pc_inc", last_pc, 32'd4);
    gap(1);
    run(mk(LD, 3'd2, 7, 0, 0, 0, 32'h8000_0010, 32'hDEAD_BEEF, 3));
    cmp("load_wdata", last_wdata, 32'hDEAD_BEEF);
    run(mk(ST, 3'd2, 0, 0, 32'hA5A5, 0, 32'h40, 0, 0));
    cmp("store_wen", last_wen, 0);
    run(mk(BR, 3'd0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0, 0));
    cmp("beq_pc_inc", last_pc, 32'hFFFF_FFF8);
    cmp("beq_wen", last_wen, 0);
    run(mk(BR, 3'd1, 0, 0, 0, 32'hFFFF_FFF8, 0, 0, 0));
    cmp("bne_pc_inc", last_pc, 32'd4);
    run(mk(BR, 3'd7, 0, 0, 0, 32'h20, 1, 0, 0));
    cmp("bgeu_pc_inc", last_pc, 32'd4);
    run(mk(JR, 3'd0, 1, 32'h100, 0, 32'hC, 32'h1004, 0, 0));
    cmp("jalr_ovrd", last_ovrd, 1);
    cmp("jalr_addr", last_oaddr, 32'h100);
    cmp("jalr_pc_inc", last_pc, 32'hC);
    cmp("jalr_wen", last_wen, 1);
    run(mk(LD, 3'd2, 9, 0, 0, 0, 32'h200, 32'h5555, MW + 1));
    cmp("tmo_wen", last_wen, 0);
    cmp("tmo_bus_err", bus_err, 1);
    run(mk(5'b00100, 3'd0, 3, 0, 0, 0, 32'h99, 0, 0));

    for (int i = 0; i < 300; i++) begin
      run(rnd());
      gap($urandom_range(0, 2));
    end

    chk = 1'b0;
    in_valid = 1'b1;
    opcode   = LD;
    alu_val  = 32'h300;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cmp("pre_rst_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_mem_req", mem_req, 0);
    cmp("mid_rst_bus_err", bus_err, 0);
    cmp("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_err = 1'b0;
    m_pc  = 32'd4;
    exp_idle();
    chk = 1'b1;
    for (int i = 0; i < 60; i++) begin
      run(rnd());
      gap($urandom_range(0, 1));
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
